noc_switch_allocator: RTL and testbench

Per-router switch allocator and credit manager for the NoC router. It takes head-flit requests from the five input ports (north, south, east, west, local), arbitrates each output port round-robin among its requesters, and grants only when the output holds at least one downstream buffer credit. It drives the crossbar select and valid signals and returns a per-input grant. It sits between the input buffers and the crossbar, and replaces the stateless grant logic with credit counting.

---
 rtl/noc_switch_allocator.sv | 98 +++++++++
 tb/tb_noc_switch_allocator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_switch_allocator.sv
// Switch allocator: round-robin per output, grants gated by downstream credits; outputs registered, 1-cycle latency.
// Backpressure: no grant while an output's credit count is zero; requesters hold until their grant bit is seen.
module noc_switch_allocator #(
  parameter int BUF_DEPTH = 4,
  parameter int CW        = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  req_valid_i,
  input  logic [14:0] req_port_addr_i,
  input  logic [4:0]  credit_en_i,
  output logic [4:0]  grant_o,
  output logic [14:0] xbar_sel_o,
  output logic [4:0]  xbar_vld_o,
  output logic [4:0]  credit_avail_o
);

  localparam int NP = 5;

  logic [NP-1:0][CW-1:0] credit_q, credit_d;
  logic [NP-1:0][2:0]    rr_ptr_q, rr_ptr_d;
  logic [NP-1:0][2:0]    sel_q, sel_d;
  logic [NP-1:0][NP-1:0] elig;      // [output][input]
  logic [NP-1:0]         out_gnt;
  logic [NP-1:0][2:0]    win_idx;
  logic [NP-1:0]         in_gnt;
  logic [NP-1:0]         avail_d;
  logic [3:0]            scan;

  // Codes 5-7 never match an output index, so illegal requests drop out here.
  always_comb begin
    elig = '0;
    for (int o = 0; o < NP; o++) begin
      for (int p = 0; p < NP; p++) begin
        elig[o][p] = req_valid_i[p] && (req_port_addr_i[3*p +: 3] == 3'(o)) && !grant_o[p];
      end
    end
  end

  always_comb begin
    out_gnt = '0;
    win_idx = '0;
    in_gnt  = '0;
    scan    = '0;
    for (int o = 0; o < NP; o++) begin
      for (int k = 0; k < NP; k++) begin
        scan = {1'b0, rr_ptr_q[o]} + 4'(k);
        if (scan >= 4'd5) scan = scan - 4'd5;
        if (!out_gnt[o] && (credit_q[o] != '0) && elig[o][scan[2:0]]) begin
          out_gnt[o] = 1'b1;
          win_idx[o] = scan[2:0];
        end
      end
      if (out_gnt[o]) in_gnt[win_idx[o]] = 1'b1;
    end
  end

  always_comb begin
    credit_d = credit_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    avail_d  = '0;
    for (int o = 0; o < NP; o++) begin
      if (out_gnt[o]) begin
        sel_d[o]    = win_idx[o];
        rr_ptr_d[o] = (win_idx[o] == 3'd4) ? 3'd0 : win_idx[o] + 3'd1;
      end
      // A return arriving at full count is dropped rather than overflowing.
      if (out_gnt[o] && !credit_en_i[o]) begin
        credit_d[o] = credit_q[o] - CW'(1);
      end else if (!out_gnt[o] && credit_en_i[o] && (credit_q[o] != CW'(BUF_DEPTH))) begin
        credit_d[o] = credit_q[o] + CW'(1);
      end
      avail_d[o] = (credit_d[o] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_o        <= '0;
      xbar_vld_o     <= '0;
      sel_q          <= '0;
      rr_ptr_q       <= '0;
      credit_avail_o <= '1;
      for (int o = 0; o < NP; o++) credit_q[o] <= CW'(BUF_DEPTH);
    end else begin
      grant_o        <= in_gnt;
      xbar_vld_o     <= out_gnt;
      sel_q          <= sel_d;
      rr_ptr_q       <= rr_ptr_d;
      credit_avail_o <= avail_d;
      credit_q       <= credit_d;
    end
  end

  assign xbar_sel_o = sel_q;

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Directed bench for noc_switch_allocator: one task per scenario with inline checks.
module tb_noc_switch_allocator;

  logic        clk_i;
  logic        rst_i;
  logic [4:0]  req_valid_i;
  logic [14:0] req_port_addr_i;
  logic [4:0]  credit_en_i;
  logic [4:0]  grant_o;
  logic [14:0] xbar_sel_o;
  logic [4:0]  xbar_vld_o;
  logic [4:0]  credit_avail_o;

  int n_cmp = 0;
  int n_err = 0;

  noc_switch_allocator #(.BUF_DEPTH(4), .CW(3)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_port_addr_i(req_port_addr_i),
    .credit_en_i    (credit_en_i),
    .grant_o        (grant_o),
    .xbar_sel_o     (xbar_sel_o),
    .xbar_vld_o     (xbar_vld_o),
    .credit_avail_o (credit_avail_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Advance one edge; outputs are then read 1 time unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i           = 1'b1;
    req_valid_i     = '0;
    req_port_addr_i = '0;
    credit_en_i     = '0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i           = 1'b1;
    req_valid_i     = 5'b11111;
    req_port_addr_i = {3'd0, 3'd4, 3'd3, 3'd2, 3'd1};
    credit_en_i     = 5'b11111;
    tick();
    rst_i = 1'b0; req_valid_i = '0; credit_en_i = '0;
    n_cmp++; if (grant_o !== 5'b0) begin n_err++; $display("FAIL reset_grant got=%b exp=%b", grant_o, 5'b0); end
    n_cmp++; if (xbar_vld_o !== 5'b0) begin n_err++; $display("FAIL reset_vld got=%b exp=%b", xbar_vld_o, 5'b0); end
    n_cmp++; if (xbar_sel_o !== 15'b0) begin n_err++; $display("FAIL reset_sel got=%h exp=%h", xbar_sel_o, 15'b0); end
    n_cmp++; if (credit_avail_o !== 5'b11111) begin n_err++; $display("FAIL reset_avail got=%b exp=%b", credit_avail_o, 5'b11111); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (grant_o !== 5'b0 || xbar_vld_o !== 5'b0 || xbar_sel_o !== 15'b0 || credit_avail_o !== 5'b11111) begin
        n_err++;
        $display("FAIL idle_%0d got g=%b v=%b s=%h a=%b exp g=0 v=0 s=0 a=11111", i, grant_o, xbar_vld_o, xbar_sel_o, credit_avail_o);
      end
    end
  endtask

  task automatic test_single_stream();
    logic [4:0] exp_g;
    logic       exp_a;
    int         ngr;
    do_reset();
    req_valid_i = 5'b00001;
    req_port_addr_i = 15'd2;
    ngr = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_g = ((k % 2 == 1) && k <= 7) ? 5'b00001 : 5'b00000;
      if (exp_g[0]) ngr++;
      exp_a = (ngr < 4);
      n_cmp++; if (grant_o !== exp_g) begin n_err++; $display("FAIL stream_grant_c%0d got=%b exp=%b", k, grant_o, exp_g); end
      n_cmp++; if (xbar_vld_o !== {2'b0, exp_g[0], 2'b0}) begin n_err++; $display("FAIL stream_vld_c%0d got=%b exp=%b", k, xbar_vld_o, {2'b0, exp_g[0], 2'b0}); end
      n_cmp++; if (credit_avail_o !== {2'b11, exp_a, 2'b11}) begin n_err++; $display("FAIL stream_avail_c%0d got=%b exp=%b", k, credit_avail_o, {2'b11, exp_a, 2'b11}); end
      if (exp_g[0]) begin
        n_cmp++; if (xbar_sel_o[8:6] !== 3'd0) begin n_err++; $display("FAIL stream_sel_c%0d got=%0d exp=0", k, xbar_sel_o[8:6]); end
      end
    end
    credit_en_i = 5'b00100;
    tick();
    credit_en_i = '0;
    n_cmp++; if (grant_o !== 5'b0) begin n_err++; $display("FAIL refill_early got=%b exp=%b", grant_o, 5'b0); end
    n_cmp++; if (credit_avail_o[2] !== 1'b1) begin n_err++; $display("FAIL refill_avail got=%b exp=1", credit_avail_o[2]); end
    tick();
    n_cmp++; if (grant_o !== 5'b00001) begin n_err++; $display("FAIL refill_grant got=%b exp=%b", grant_o, 5'b00001); end
    n_cmp++; if (credit_avail_o[2] !== 1'b0) begin n_err++; $display("FAIL refill_drain got=%b exp=0", credit_avail_o[2]); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (grant_o !== 5'b0) begin n_err++; $display("FAIL refill_extra_%0d got=%b exp=%b", k, grant_o, 5'b0); end
    end
    req_valid_i = '0;
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_g [6];
    logic [2:0] exp_s [6];
    exp_g = '{5'b00001, 5'b00010, 5'b01000, 5'b00001, 5'b00010, 5'b01000};
    exp_s = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd3};
    do_reset();
    req_valid_i     = 5'b01011;
    req_port_addr_i = {3'd0, 3'd4, 3'd0, 3'd4, 3'd4};
    credit_en_i     = 5'b10000;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++; if (grant_o !== exp_g[k]) begin n_err++; $display("FAIL rr_grant_%0d got=%b exp=%b", k, grant_o, exp_g[k]); end
      n_cmp++; if (xbar_sel_o[14:12] !== exp_s[k]) begin n_err++; $display("FAIL rr_sel_%0d got=%0d exp=%0d", k, xbar_sel_o[14:12], exp_s[k]); end
      n_cmp++; if (xbar_vld_o !== 5'b10000) begin n_err++; $display("FAIL rr_vld_%0d got=%b exp=%b", k, xbar_vld_o, 5'b10000); end
      n_cmp++; if (credit_avail_o !== 5'b11111) begin n_err++; $display("FAIL rr_avail_%0d got=%b exp=%b", k, credit_avail_o, 5'b11111); end
    end
    req_valid_i = '0; credit_en_i = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_valid_i     = 5'b00010;
    req_port_addr_i = {3'd0, 3'd0, 3'd0, 3'd3, 3'd0};
    for (int k = 1; k <= 6; k++) tick();
    credit_en_i = 5'b01000;
    tick();
    credit_en_i = '0;
    n_cmp++; if (grant_o !== 5'b00010) begin n_err++; $display("FAIL simul_grant got=%b exp=%b", grant_o, 5'b00010); end
    n_cmp++; if (credit_avail_o[3] !== 1'b1) begin n_err++; $display("FAIL simul_avail got=%b exp=1", credit_avail_o[3]); end
    tick();
    tick();
    n_cmp++; if (grant_o !== 5'b00010) begin n_err++; $display("FAIL simul_last_grant got=%b exp=%b", grant_o, 5'b00010); end
    n_cmp++; if (credit_avail_o[3] !== 1'b0) begin n_err++; $display("FAIL simul_empty got=%b exp=0", credit_avail_o[3]); end
    tick();
    tick();
    n_cmp++; if (grant_o !== 5'b0) begin n_err++; $display("FAIL simul_nocredit got=%b exp=%b", grant_o, 5'b0); end

    // Excess returns at full count must saturate at four.
    do_reset();
    credit_en_i = 5'b01000;
    tick();
    tick();
    credit_en_i = '0;
    n_cmp++; if (credit_avail_o !== 5'b11111) begin n_err++; $display("FAIL sat_avail got=%b exp=%b", credit_avail_o, 5'b11111); end
    req_valid_i     = 5'b00010;
    req_port_addr_i = {3'd0, 3'd0, 3'd0, 3'd3, 3'd0};
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 7) begin
        n_cmp++; if (credit_avail_o[3] !== 1'b0) begin n_err++; $display("FAIL sat_drain got=%b exp=0", credit_avail_o[3]); end
      end
      if (k == 9) begin
        n_cmp++; if (grant_o !== 5'b0) begin n_err++; $display("FAIL sat_overflow_grant got=%b exp=%b", grant_o, 5'b0); end
      end
    end
    req_valid_i = '0;
  endtask

  task automatic test_full_parallel();
    do_reset();
    req_valid_i     = 5'b11111;
    req_port_addr_i = {3'd0, 3'd4, 3'd3, 3'd2, 3'd1};
    tick();
    req_valid_i = '0;
    n_cmp++; if (grant_o !== 5'b11111) begin n_err++; $display("FAIL par_grant got=%b exp=%b", grant_o, 5'b11111); end
    n_cmp++; if (xbar_vld_o !== 5'b11111) begin n_err++; $display("FAIL par_vld got=%b exp=%b", xbar_vld_o, 5'b11111); end
    n_cmp++; if (xbar_sel_o !== {3'd3, 3'd2, 3'd1, 3'd0, 3'd4}) begin n_err++; $display("FAIL par_sel got=%h exp=%h", xbar_sel_o, {3'd3, 3'd2, 3'd1, 3'd0, 3'd4}); end
    tick();
    n_cmp++; if (xbar_vld_o !== 5'b0) begin n_err++; $display("FAIL par_idle_vld got=%b exp=%b", xbar_vld_o, 5'b0); end
    n_cmp++; if (xbar_sel_o !== {3'd3, 3'd2, 3'd1, 3'd0, 3'd4}) begin n_err++; $display("FAIL par_sel_hold got=%h exp=%h", xbar_sel_o, {3'd3, 3'd2, 3'd1, 3'd0, 3'd4}); end
  endtask

  task automatic test_illegal_and_reset();
    do_reset();
    req_valid_i     = 5'b00100;
    req_port_addr_i = {3'd0, 3'd0, 3'd6, 3'd0, 3'd0};
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++; if (grant_o !== 5'b0 || xbar_vld_o !== 5'b0) begin n_err++; $display("FAIL illegal_%0d got g=%b v=%b exp g=0 v=0", k, grant_o, xbar_vld_o); end
    end
    do_reset();
    req_valid_i     = 5'b00001;
    req_port_addr_i = 15'd2;
    for (int k = 1; k <= 6; k++) tick();
    n_cmp++; if (credit_avail_o[2] !== 1'b1) begin n_err++; $display("FAIL midrst_pre got=%b exp=1", credit_avail_o[2]); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_cmp++; if (grant_o !== 5'b0) begin n_err++; $display("FAIL midrst_grant got=%b exp=%b", grant_o, 5'b0); end
    n_cmp++; if (credit_avail_o !== 5'b11111) begin n_err++; $display("FAIL midrst_avail got=%b exp=%b", credit_avail_o, 5'b11111); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 5) begin
        n_cmp++; if (credit_avail_o[2] !== 1'b1) begin n_err++; $display("FAIL midrst_refill got=%b exp=1", credit_avail_o[2]); end
      end
      if (k == 7) begin
        n_cmp++; if (grant_o !== 5'b00001 || credit_avail_o[2] !== 1'b0) begin n_err++; $display("FAIL midrst_fourth got g=%b a=%b exp g=00001 a=0", grant_o, credit_avail_o[2]); end
      end
      if (k == 9) begin
        n_cmp++; if (grant_o !== 5'b0) begin n_err++; $display("FAIL midrst_fifth got=%b exp=%b", grant_o, 5'b0); end
      end
    end
    req_valid_i = '0;
  endtask

  initial begin
    rst_i           = 1'b1;
    req_valid_i     = '0;
    req_port_addr_i = '0;
    credit_en_i     = '0;
    test_reset();
    test_single_stream();
    test_round_robin();
    test_simultaneous();
    test_full_parallel();
    test_illegal_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
